// File: rtl/ccc_dyncfg_sequencer.sv
// MSS CCC dynamic-configuration sequencer: serial config load, PLL lock qualification,
// fabric reset control and lock-loss monitoring. Optional SDOUT readback: CCC_CFG_READBACK_EN.
//
// state     | meaning
// ST_IDLE   | waiting for START after reset
// ST_SHIFT  | shifting config word into the CCC (SSHIFT=1, 2 cycles per bit)
// ST_UPDATE | SUPDATE strobe, 2 cycles
// ST_WAIT   | waiting for synced lock, timeout armed
// ST_STABLE | counting consecutive synced-lock-high cycles
// ST_RUN    | locked; fabric reset released, watching for lock loss
// ST_ERROR  | lock timeout or readback mismatch; waits for START
module ccc_dyncfg_sequencer #(
  parameter int CFG_W        = 81,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 1023,
  parameter int CNT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CFG_W-1:0] i_cfg_word,
  input  logic             i_lock,
  input  logic             i_sdout,
  output logic             o_sclk,
  output logic             o_sdin,
  output logic             o_sshift,
  output logic             o_supdate,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_err,
  output logic             o_fab_rstn,
  output logic [CNT_W-1:0] o_loss_cnt
);

  localparam int BIT_W    = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam int TMO_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int STB_W    = (LOCK_STABLE > 2) ? $clog2(LOCK_STABLE - 1) : 1;
  localparam int STB_LOAD = (LOCK_STABLE > 2) ? LOCK_STABLE - 2 : 0;

  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(CFG_W - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LOAD_V = STB_W'(STB_LOAD);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SHIFT, ST_UPDATE, ST_WAIT, ST_STABLE, ST_RUN, ST_ERROR
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_sync;
  logic [CFG_W-1:0]   r_shreg, w_shreg_nxt;
  logic [BIT_W-1:0]   r_bit, w_bit_nxt;
  logic               r_phase, w_phase_nxt;
  logic               r_upd, w_upd_nxt;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
  logic [STB_W-1:0]   r_stb, w_stb_nxt;
  logic [1:0]         r_err, w_err_nxt;
  logic [CNT_W-1:0]   r_loss, w_loss_nxt;
  logic               w_lock_s;
  logic               w_accept;
  logic               w_in_shift;

`ifdef CCC_CFG_READBACK_EN
  logic               r_pass, w_pass_nxt;
  logic [CFG_W-1:0]   r_rb, w_rb_nxt;
`else
  logic               w_unused_sdout;
  assign w_unused_sdout = i_sdout;
`endif

  assign w_lock_s = r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_sync  <= '0;
      r_shreg <= '0;
      r_bit   <= '0;
      r_phase <= 1'b0;
      r_upd   <= 1'b0;
      r_tmo   <= '0;
      r_stb   <= '0;
      r_err   <= '0;
      r_loss  <= '0;
`ifdef CCC_CFG_READBACK_EN
      r_pass  <= 1'b0;
      r_rb    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[0], i_lock};
      r_shreg <= w_shreg_nxt;
      r_bit   <= w_bit_nxt;
      r_phase <= w_phase_nxt;
      r_upd   <= w_upd_nxt;
      r_tmo   <= w_tmo_nxt;
      r_stb   <= w_stb_nxt;
      r_err   <= w_err_nxt;
      r_loss  <= w_loss_nxt;
`ifdef CCC_CFG_READBACK_EN
      r_pass  <= w_pass_nxt;
      r_rb    <= w_rb_nxt;
`endif
    end
  end

  assign w_accept = i_start &&
                    ((r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_ERROR));

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bit_nxt   = r_bit;
    w_phase_nxt = r_phase;
    w_upd_nxt   = r_upd;
    w_tmo_nxt   = r_tmo;
    w_stb_nxt   = r_stb;
    w_err_nxt   = r_err;
    w_loss_nxt  = r_loss;
`ifdef CCC_CFG_READBACK_EN
    w_pass_nxt  = r_pass;
    w_rb_nxt    = r_rb;
`endif

    case (r_state)
      ST_SHIFT: begin
        w_phase_nxt = ~r_phase;
        if (r_phase) begin
          // Rotate rather than shift so the word is intact again after every pass.
          w_shreg_nxt = {r_shreg[0], r_shreg[CFG_W-1:1]};
`ifdef CCC_CFG_READBACK_EN
          w_rb_nxt = {i_sdout, r_rb[CFG_W-1:1]};
`endif
          if (r_bit == LAST_BIT) begin
            w_bit_nxt = '0;
`ifdef CCC_CFG_READBACK_EN
            if (!r_pass) begin
              w_pass_nxt = 1'b1;
            end else if (w_rb_nxt != w_shreg_nxt) begin
              w_state_nxt = ST_ERROR;
              w_err_nxt   = 2'b10;
            end else begin
              w_state_nxt = ST_UPDATE;
            end
`else
            w_state_nxt = ST_UPDATE;
`endif
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      ST_UPDATE: begin
        w_upd_nxt = ~r_upd;
        if (r_upd) begin
          w_state_nxt = ST_WAIT;
          w_tmo_nxt   = TMO_LOAD;
        end
      end
      ST_WAIT: begin
        // The cycle that first sees lock_s high counts as the first stable cycle.
        if (w_lock_s) begin
          if (LOCK_STABLE <= 1) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_STABLE;
            w_stb_nxt   = STB_LOAD_V;
          end
        end else if (r_tmo == '0) begin
          w_state_nxt = ST_ERROR;
          w_err_nxt   = 2'b01;
        end else begin
          w_tmo_nxt = r_tmo - 1'b1;
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT;
          w_tmo_nxt   = TMO_LOAD;
        end else if (r_stb == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_stb_nxt = r_stb - 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT;
          w_tmo_nxt   = TMO_LOAD;
          if (r_loss != '1) w_loss_nxt = r_loss + 1'b1;
        end
      end
      default: ;
    endcase

    // START overrides any RUN lock-loss transition; the loss is still counted above.
    if (w_accept) begin
      w_state_nxt = ST_SHIFT;
      w_shreg_nxt = i_cfg_word;
      w_bit_nxt   = '0;
      w_phase_nxt = 1'b0;
      w_upd_nxt   = 1'b0;
      w_err_nxt   = 2'b00;
`ifdef CCC_CFG_READBACK_EN
      w_pass_nxt  = 1'b0;
`endif
    end
  end

  assign w_in_shift = (r_state == ST_SHIFT);
  assign o_sshift   = w_in_shift;
  assign o_sclk     = w_in_shift & r_phase;
  assign o_sdin     = w_in_shift & r_shreg[0];
  assign o_supdate  = (r_state == ST_UPDATE);
  assign o_busy     = !((r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_ERROR));
  assign o_done     = (r_state == ST_RUN);
  assign o_fab_rstn = (r_state == ST_RUN);
  assign o_err      = r_err;
  assign o_loss_cnt = r_loss;

endmodule
